// File: rtl/decoder_pkg.sv
// Shared constants and the reference decode function for the decoder block.
package decoder_pkg;

  localparam int unsigned DEF_SIZE   = 2;
  localparam int unsigned DEF_OUT_SZ = 4;

  // Widest select and pattern the shared function supports.
  localparam int unsigned SEL_W   = 32;
  localparam int unsigned MAX_OUT = 64;

  // One-hot pattern with bit sel set when sel < width; all zeros otherwise.
  function automatic logic [MAX_OUT-1:0] onehot(input logic [SEL_W-1:0] sel,
                                                input int unsigned     width);
    logic [MAX_OUT-1:0] pat;
    pat = '0;
    for (int unsigned i = 0; i < MAX_OUT; i++) begin
      pat[i] = (i < width) && (sel == SEL_W'(i));
    end
    return pat;
  endfunction

endpackage

// File: rtl/decoder_core.sv
// Combinational one-hot decode with an out-of-range flag.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int unsigned SIZE   = DEF_SIZE,
  parameter int unsigned OUT_SZ = DEF_OUT_SZ
) (
  input  logic [SIZE-1:0]   in,
  output logic [OUT_SZ-1:0] out,
  output logic              oor
);

  // Reject parameter sets the decode cannot represent.
  if (SIZE < 1 || SIZE > SEL_W) begin : g_bad_size
    $error("decoder_core: SIZE must be in 1..%0d", SEL_W);
  end
  if (OUT_SZ < 1 || OUT_SZ > MAX_OUT ||
      (SIZE < 63 && 64'(OUT_SZ) > (64'd1 << SIZE))) begin : g_bad_out_sz
    $error("decoder_core: OUT_SZ must be in 1..min(2**SIZE, %0d)", MAX_OUT);
  end

  logic [MAX_OUT-1:0] pat;

  // Full-width pattern; bits at and above OUT_SZ are always zero.
  always_comb begin
    pat = onehot(SEL_W'(in), OUT_SZ);
  end

  // An empty pattern means the select fell outside the output range.
  always_comb begin
    out = pat[OUT_SZ-1:0];
    oor = ~|pat;
  end

endmodule

// File: rtl/decoder.sv
// Decoder top: combinational decode plus an enabled capture register stage.
module decoder
  import decoder_pkg::*;
#(
  parameter int unsigned SIZE   = DEF_SIZE,
  parameter int unsigned OUT_SZ = DEF_OUT_SZ
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SIZE-1:0]   in,
  input  logic              en,
  output logic [OUT_SZ-1:0] out,
  output logic              oor,
  output logic [OUT_SZ-1:0] out_q,
  output logic              oor_q,
  output logic              valid_q
);

  decoder_core #(
    .SIZE   (SIZE),
    .OUT_SZ (OUT_SZ)
  ) u_core (
    .in  (in),
    .out (out),
    .oor (oor)
  );

  // Capture the decode on enabled edges; clear asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      oor_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (en) begin
      out_q   <= out;
      oor_q   <= oor;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Directed and random checks of decoder with default and reduced output widths.
`timescale 1ns/1ps
module tb_decoder;
  import decoder_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] in_a;
  logic [1:0] in_b;

  logic [3:0] out_a, out_q_a;
  logic       oor_a, oor_q_a, valid_q_a;
  logic [2:0] out_b, out_q_b;
  logic       oor_b, oor_q_b, valid_q_b;

  int total;
  int bad;

  decoder #(.SIZE(2), .OUT_SZ(4)) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in_a),
    .en      (en),
    .out     (out_a),
    .oor     (oor_a),
    .out_q   (out_q_a),
    .oor_q   (oor_q_a),
    .valid_q (valid_q_a)
  );

  decoder #(.SIZE(2), .OUT_SZ(3)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in_b),
    .en      (en),
    .out     (out_b),
    .oor     (oor_b),
    .out_q   (out_q_b),
    .oor_q   (oor_q_b),
    .valid_q (valid_q_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  sweep_exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0]  exp_q;
  logic        exp_oor_q;
  logic [63:0] ref_pat;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    in_a  = 2'd0;
    in_b  = 2'd0;
    #3;

    check("reset out_q", 32'(out_q_a), 32'h0);
    check("reset oor_q", 32'(oor_q_a), 32'h0);
    check("reset valid_q", 32'(valid_q_a), 32'h0);

    // Combinational sweep, clock irrelevant.
    for (int i = 0; i < 4; i++) begin
      in_a = 2'(i);
      #10;
      check($sformatf("sweep out in=%0d", i), 32'(out_a), 32'(sweep_exp[i]));
      check($sformatf("sweep oor in=%0d", i), 32'(oor_a), 32'h0);
    end

    // Registers hold reset while rst_n low even with en=1.
    en = 1'b1;
    tick();
    check("held in reset out_q", 32'(out_q_a), 32'h0);
    check("held in reset valid_q", 32'(valid_q_a), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    in_a  = 2'd2;
    tick();
    check("reg out_q in=2", 32'(out_q_a), 32'h4);
    check("reg oor_q in=2", 32'(oor_q_a), 32'h0);
    check("reg valid_q", 32'(valid_q_a), 32'h1);

    @(negedge clk);
    en   = 1'b0;
    in_a = 2'd1;
    tick();
    check("hold out_q en=0", 32'(out_q_a), 32'h4);
    check("hold valid_q en=0", 32'(valid_q_a), 32'h1);
    check("comb in=1 while held", 32'(out_a), 32'h2);

    // Reduced width: in=3 is out of range.
    @(negedge clk);
    in_b = 2'd2;
    #1;
    check("oor unit in=2 out", 32'(out_b), 32'h4);
    check("oor unit in=2 oor", 32'(oor_b), 32'h0);
    in_b = 2'd3;
    #1;
    check("oor unit in=3 out", 32'(out_b), 32'h0);
    check("oor unit in=3 oor", 32'(oor_b), 32'h1);
    en = 1'b1;
    tick();
    check("oor unit out_q", 32'(out_q_b), 32'h0);
    check("oor unit oor_q", 32'(oor_q_b), 32'h1);
    check("oor unit valid_q", 32'(valid_q_b), 32'h1);

    // Async reset between edges.
    @(negedge clk);
    in_a = 2'd3;
    tick();
    check("pre-reset out_q", 32'(out_q_a), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    check("async out_q", 32'(out_q_a), 32'h0);
    check("async oor_q b", 32'(oor_q_b), 32'h0);
    check("async valid_q", 32'(valid_q_a), 32'h0);
    check("async comb out", 32'(out_a), 32'h8);
    in_a = 2'd1;
    #1;
    check("comb tracks in reset", 32'(out_a), 32'h2);
    tick();
    check("reset holds with en", 32'(out_q_a), 32'h0);

    // First edge after release captures.
    @(negedge clk);
    rst_n = 1'b1;
    in_a  = 2'd0;
    tick();
    check("first edge out_q", 32'(out_q_a), 32'h1);
    check("first edge valid_q", 32'(valid_q_a), 32'h1);

    // Random: comb decode vs shared function and hand shift; register vs last enabled sample.
    exp_q     = 4'b0001;
    exp_oor_q = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      in_a = 2'($urandom_range(0, 3));
      in_b = 2'($urandom_range(0, 3));
      en   = 1'($urandom_range(0, 1));
      #1;
      ref_pat = onehot(32'(in_a), 4);
      check("rand out vs onehot", 32'(out_a), 32'(ref_pat[3:0]));
      check("rand out vs shift", 32'(out_a), 32'(4'b0001 << in_a));
      check("rand oor b", 32'(oor_b), 32'(in_b == 2'd3));
      if (en) begin
        exp_q     = out_a;
        exp_oor_q = oor_a;
      end
      tick();
      check("rand out_q", 32'(out_q_a), 32'(exp_q));
      check("rand oor_q", 32'(oor_q_a), 32'(exp_oor_q));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 Parameter SIZE, default 2: select input width in bits; SIZE SHALL be >= 1.
REQ-002 Parameter OUT_SZ, default 4: one-hot output width; OUT_SZ SHALL satisfy 1 <= OUT_SZ <= 2**SIZE, checked at elaboration.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset, ports named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all registered outputs.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in  input  SIZE  binary select value.
REQ-007 en  input  1  capture enable for the registered path.
REQ-008 out  output  OUT_SZ  combinational one-hot decode of in.
REQ-009 oor  output  1  combinational flag; high when in >= OUT_SZ.
REQ-010 out_q  output  OUT_SZ  registered copy of out.
REQ-011 oor_q  output  1  registered copy of oor.
REQ-012 valid_q  output  1  high once out_q holds a captured value since reset.

Function
REQ-013 out SHALL have exactly bit in set when in < OUT_SZ; all other bits SHALL be 0.
REQ-014 out SHALL be all zeros and oor SHALL be 1 when in >= OUT_SZ; otherwise oor SHALL be 0.
REQ-015 out and oor SHALL be purely combinational; clk, rst_n and en SHALL have no effect on them.
REQ-016 out and oor SHALL settle within the same time step in which in changes, with no clock edge needed.
REQ-017 out SHALL never have more than one bit set; if oor is 0, exactly one bit SHALL be set.
REQ-018 On a rising clk with en=1 and rst_n=1, out_q SHALL load out, oor_q SHALL load oor, and valid_q SHALL go to 1.
REQ-019 On a rising clk with en=0, out_q, oor_q and valid_q SHALL hold their values.
REQ-020 The registered path SHALL have latency exactly one clock; there SHALL be no handshake or backpressure.
REQ-021 X or Z bits on in SHALL NOT be resolved by the design; the bench drives only known values.

Reset
REQ-022 rst_n low SHALL immediately set out_q=0, oor_q=0 and valid_q=0, independent of clk.
REQ-023 The registers SHALL hold their reset values while rst_n is low, including when en=1.
REQ-024 On the first rising clk after rst_n deasserts, the registers SHALL capture normally if en=1.
REQ-025 A reset asserted mid-operation SHALL clear the registered outputs without affecting out or oor.

Structure
REQ-026 Package decoder_pkg SHALL hold the default SIZE and OUT_SZ constants.
REQ-027 decoder_pkg SHALL hold a pure function onehot(sel, width) returning the decode pattern, shared by the RTL and the bench.
REQ-028 One sub-module, decoder_core (SIZE, OUT_SZ; in -> out, oor), SHALL hold the combinational logic.
REQ-029 decoder SHALL instantiate decoder_core and add the enable register stage.

Verification
REQ-030 Combinational sweep with defaults: in=0,1,2,3, check out 10 time units later -> out=0001, 0010, 0100, 1000 and oor=0 each time.
REQ-031 Registered path: en=1, in=2, one rising clk -> out_q=0100, oor_q=0, valid_q=1; then in=1 with en=0 and one clk -> out_q stays 0100.
REQ-032 Out of range, SIZE=2 and OUT_SZ=3: in=3 -> out=000 and oor=1; after one clk with en=1 -> out_q=000 and oor_q=1.
REQ-033 Async reset: with out_q=1000, drive rst_n=0 between clock edges -> out_q=0, oor_q=0 and valid_q=0 at once, while out still tracks in.
REQ-034 Random check: 1000 random in values and en patterns -> out equals decoder_pkg onehot(), and out_q equals out as sampled at the last enabled edge.
